// File: rtl/des_key_sched_ctrl.sv
// rtl/des_key_sched_ctrl.sv - two-channel arbiter and sequencer for a shared DES key-schedule generator
// Keeps a one-entry {key, dir} -> round-key cache so repeated requests skip regeneration.
module des_key_sched_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req_valid,
  input  logic [63:0]  req_key0,
  input  logic [63:0]  req_key1,
  input  logic [1:0]   req_dir,
  output logic [1:0]   req_ready,
  output logic [1:0]   rsp_valid,
  input  logic [1:0]   rsp_ready,
  output logic [767:0] rsp_keys,
  output logic         rsp_err,
  input  logic         cache_flush,
  output logic         kg_valid_i,
  output logic [63:0]  kg_key,
  output logic         kg_dir,
  input  logic         kg_valid_o,
  input  logic [767:0] kg_round_keys
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_HIT   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t             r_state;
  state_t             w_next_state;
  logic               r_ptr;
  logic               r_id;
  logic               r_cache_v;
  logic [63:0]        r_tag_key;
  logic               r_tag_dir;
  logic [CNT_W-1:0]   r_cnt;
  logic [767:0]       r_rsp_keys;
  logic               r_rsp_err;
  logic [63:0]        r_kg_key;
  logic               r_kg_dir;

  logic               w_any_req;
  logic               w_gnt_id;
  logic [63:0]        w_req_key;
  logic               w_req_dir;
  logic               w_hit;
  logic               w_timeout;

  // Round-robin pointer only matters when both channels are requesting.
  assign w_any_req = |req_valid;
  assign w_gnt_id  = (req_valid == 2'b11) ? r_ptr : req_valid[1];
  assign w_req_key = w_gnt_id ? req_key1 : req_key0;
  assign w_req_dir = req_dir[w_gnt_id];
  assign w_hit     = r_cache_v && (w_req_key == r_tag_key) && (w_req_dir == r_tag_dir);
  assign w_timeout = (r_cnt == CNT_LAST);

  always_comb begin
    w_next_state = r_state;
    req_ready    = 2'b00;
    rsp_valid    = 2'b00;
    kg_valid_i   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          req_ready    = w_gnt_id ? 2'b10 : 2'b01;
          w_next_state = w_hit ? S_HIT : S_ISSUE;
        end
      end
      S_ISSUE: begin
        kg_valid_i   = 1'b1;
        w_next_state = S_WAIT;
      end
      S_WAIT: begin
        if (kg_valid_o || w_timeout) begin
          w_next_state = S_DONE;
        end
      end
      S_HIT: begin
        w_next_state = S_DONE;
      end
      S_DONE: begin
        rsp_valid = r_id ? 2'b10 : 2'b01;
        if (rsp_ready[r_id]) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
    // req_valid is a live input, so the accept pulse is masked while reset is held.
    if (rst) begin
      req_ready = 2'b00;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= 1'b0;
      r_id       <= 1'b0;
      r_cache_v  <= 1'b0;
      r_tag_key  <= '0;
      r_tag_dir  <= 1'b0;
      r_cnt      <= '0;
      r_rsp_keys <= '0;
      r_rsp_err  <= 1'b0;
      r_kg_key   <= '0;
      r_kg_dir   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_id     <= w_gnt_id;
            r_kg_key <= w_req_key;
            r_kg_dir <= w_req_dir;
          end
        end
        S_ISSUE: begin
          r_cnt <= '0;
        end
        S_WAIT: begin
          r_cnt <= r_cnt + CNT_ONE;
          if (kg_valid_o) begin
            r_rsp_keys <= kg_round_keys;
            r_tag_key  <= r_kg_key;
            r_tag_dir  <= r_kg_dir;
            r_cache_v  <= 1'b1;
            r_rsp_err  <= 1'b0;
          end else if (w_timeout) begin
            r_rsp_err <= 1'b1;
            r_cache_v <= 1'b0;
          end
        end
        S_HIT: begin
          r_rsp_err <= 1'b0;
        end
        S_DONE: begin
          if (rsp_ready[r_id]) begin
            r_ptr <= ~r_id;
          end
        end
        default: begin
        end
      endcase
      // Placed last so a flush overrides a same-cycle capture; the data is still delivered.
      if (cache_flush) begin
        r_cache_v <= 1'b0;
      end
    end
  end

  assign rsp_keys = r_rsp_keys;
  assign rsp_err  = r_rsp_err;
  assign kg_key   = r_kg_key;
  assign kg_dir   = r_kg_dir;

endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// tb/tb_des_key_sched_ctrl.sv - self-checking bench for des_key_sched_ctrl
// Transaction-timeline model plus a behavioural DES key-schedule generator.
module tb_des_key_sched_ctrl;

  localparam int TIMEOUT = 64;
  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_B = 64'h0123456789ABCDEF;
  localparam logic [63:0] KEY_C = 64'hFEDCBA9876543210;
  localparam logic [63:0] KEY_D = 64'h0E329232EA6D0D73;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [1:0]   req_valid = 2'b00;
  logic [63:0]  req_key0 = '0;
  logic [63:0]  req_key1 = '0;
  logic [1:0]   req_dir = 2'b00;
  logic [1:0]   req_ready;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready = 2'b00;
  logic [767:0] rsp_keys;
  logic         rsp_err;
  logic         cache_flush = 1'b0;
  logic         kg_valid_i;
  logic [63:0]  kg_key;
  logic         kg_dir;
  logic         kg_valid_o = 1'b0;
  logic [767:0] kg_round_keys = '0;

  des_key_sched_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_key0(req_key0), .req_key1(req_key1), .req_dir(req_dir),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_keys(rsp_keys), .rsp_err(rsp_err), .cache_flush(cache_flush),
    .kg_valid_i(kg_valid_i), .kg_key(kg_key), .kg_dir(kg_dir),
    .kg_valid_o(kg_valid_o), .kg_round_keys(kg_round_keys)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [767:0] act, input logic [767:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  int PC1 [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,
                   60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,
                   29,21,13,5,28,20,12,4};
  int PC2 [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                   41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  // Encrypt order puts K1 at the top; decrypt order puts K16 at the top.
  function automatic logic [767:0] des_ks(input logic [63:0] key, input logic d);
    logic [55:0]  cd;
    logic [27:0]  c;
    logic [27:0]  dd;
    logic [47:0]  k;
    logic [767:0] r;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1[i]];
    c = cd[55:28];
    dd = cd[27:0];
    r = '0;
    for (int rnd = 0; rnd < 16; rnd++) begin
      for (int s = 0; s < SHIFTS[rnd]; s++) begin
        c = {c[26:0], c[27]};
        dd = {dd[26:0], dd[27]};
      end
      cd = {c, dd};
      for (int j = 0; j < 48; j++) k[47-j] = cd[56-PC2[j]];
      if (d) r[767-48*rnd -: 48] = k;
      else   r[47+48*rnd -: 48] = k;
    end
    return r;
  endfunction

  // Generator stand-in: replies gen_lat cycles after the start pulse unless gen_dead.
  int gen_lat = 3;
  bit gen_dead = 1'b0;
  bit flush_on_done = 1'b0;
  always begin
    logic [63:0] gk;
    logic        gd;
    @(negedge clk);
    if (kg_valid_i === 1'b1 && !gen_dead && !rst) begin
      gk = kg_key;
      gd = kg_dir;
      repeat (gen_lat) @(posedge clk);
      #1;
      kg_valid_o = 1'b1;
      kg_round_keys = des_ks(gk, gd);
      if (flush_on_done) cache_flush = 1'b1;
      @(posedge clk);
      #1;
      kg_valid_o = 1'b0;
      cache_flush = 1'b0;
    end
  end

  int           cyc = 0;
  bit           m_busy = 1'b0;
  int           m_id = 0;
  int           m_ptr = 0;
  bit           m_cv = 1'b0;
  logic [63:0]  m_tk = '0;
  logic         m_td = 1'b0;
  logic [767:0] m_ck = '0;
  bit           m_hit = 1'b0;
  bit           m_to = 1'b0;
  int           m_kcyc = -1;
  int           m_rcyc = 0;
  logic [63:0]  m_key = '0;
  logic         m_dir = 1'b0;
  logic [767:0] m_keys = '0;
  int           kg_pulses = 0;
  int           last_grant_cyc = 0;
  int           last_rsp_cyc = 0;
  logic [1:0]   grant_log [$];

  // Per-cycle compare against the expected transaction timeline.
  always @(negedge clk) begin
    logic [1:0] exp_rr;
    logic [1:0] exp_rv;
    int gid;
    cyc++;
    if (rst) begin
      m_busy = 1'b0;
      m_ptr = 0;
      m_cv = 1'b0;
      chk("rst_ctrl_outputs", {req_ready, rsp_valid, rsp_err, kg_valid_i, kg_dir, kg_key}, '0);
      chk("rst_rsp_keys", rsp_keys, '0);
    end else begin
      if (kg_valid_i === 1'b1) kg_pulses++;
      if (!m_busy) begin
        exp_rr = 2'b00;
        if (req_valid != 2'b00) begin
          gid = (req_valid == 2'b11) ? m_ptr : (req_valid[1] ? 1 : 0);
          exp_rr = (gid == 1) ? 2'b10 : 2'b01;
          m_id = gid;
          m_key = (gid == 1) ? req_key1 : req_key0;
          m_dir = req_dir[gid];
          m_hit = m_cv && (m_tk == m_key) && (m_td == m_dir);
          m_to = !m_hit && gen_dead;
          m_kcyc = m_hit ? -1 : cyc + 1;
          m_rcyc = m_hit ? cyc + 2 : (m_to ? cyc + 2 + TIMEOUT : cyc + 2 + gen_lat);
          m_keys = m_hit ? m_ck : des_ks(m_key, m_dir);
          m_busy = 1'b1;
          grant_log.push_back(exp_rr);
          last_grant_cyc = cyc;
        end
        chk("req_ready_idle", req_ready, exp_rr);
        chk("kg_valid_i_idle", kg_valid_i, 1'b0);
        chk("rsp_valid_idle", rsp_valid, 2'b00);
      end else begin
        chk("req_ready_busy", req_ready, 2'b00);
        chk("kg_valid_i", kg_valid_i, (cyc == m_kcyc));
        chk("kg_key_stable", kg_key, m_key);
        chk("kg_dir_stable", kg_dir, m_dir);
        exp_rv = (cyc >= m_rcyc) ? ((m_id == 1) ? 2'b10 : 2'b01) : 2'b00;
        chk("rsp_valid", rsp_valid, exp_rv);
        if (!m_hit && cyc == m_rcyc - 1) begin
          if (m_to) m_cv = 1'b0;
          else begin
            m_cv = 1'b1;
            m_tk = m_key;
            m_td = m_dir;
            m_ck = m_keys;
          end
        end
        if (cyc >= m_rcyc) begin
          chk("rsp_err", rsp_err, m_to);
          if (!m_to) chk("rsp_keys", rsp_keys, m_keys);
          if (cyc == m_rcyc) last_rsp_cyc = cyc;
          if (rsp_ready[m_id]) begin
            m_busy = 1'b0;
            m_ptr = 1 - m_id;
          end
        end
      end
      if (cache_flush) m_cv = 1'b0;
    end
  end

  task automatic request(input int ch, input logic [63:0] key, input logic d);
    int n = 0;
    @(posedge clk);
    #1;
    if (ch == 0) req_key0 = key;
    else         req_key1 = key;
    req_dir[ch] = d;
    req_valid[ch] = 1'b1;
    while (n < 300) begin
      @(posedge clk);
      #1;
      if (!m_busy) n++;
      else break;
    end
    if (n >= 300) chk("grant_within_budget", 1'b0, 1'b1);
    req_valid[ch] = 1'b0;
  endtask

  task automatic wait_rsp(input int ch, input int hold, output logic [767:0] keys,
                          output logic [1:0] rv, output logic err);
    int n = 0;
    while (n < 300) begin
      if (rsp_valid[ch]) break;
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 300) chk("rsp_within_budget", 1'b0, 1'b1);
    keys = rsp_keys;
    rv = rsp_valid;
    err = rsp_err;
    repeat (hold) @(posedge clk);
    #1;
    rsp_ready[ch] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[ch] = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [767:0] k1;
    logic [767:0] k2;
    logic [1:0]   rv;
    logic         err;
    int           p0;
    int           n;

    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("model_K1_encrypt", des_ks(KEY_A, 1'b1) >> 720, 48'h1B02EFFC7072);
    chk("model_K16_encrypt", des_ks(KEY_A, 1'b1) & {720'd0, {48{1'b1}}}, 48'hCB3D8B0E17F5);

    // Contention: both channels requesting continuously from reset.
    grant_log.delete();
    rsp_ready = 2'b11;
    req_key0 = KEY_B;
    req_key1 = KEY_C;
    req_dir = 2'b11;
    req_valid = 2'b11;
    n = 0;
    while (grant_log.size() < 3 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    req_valid = 2'b00;
    n = 0;
    while (m_busy && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    rsp_ready = 2'b00;
    chk("contention_count", grant_log.size(), 3);
    if (grant_log.size() >= 3) begin
      chk("contention_grant0", grant_log[0], 2'b01);
      chk("contention_grant1", grant_log[1], 2'b10);
      chk("contention_grant2", grant_log[2], 2'b01);
    end

    pulse_reset();

    // Single miss.
    p0 = kg_pulses;
    request(0, KEY_A, 1'b1);
    wait_rsp(0, 0, k1, rv, err);
    chk("miss_kg_pulses", kg_pulses - p0, 1);
    chk("miss_rsp_valid", rv, 2'b01);
    chk("miss_rsp_err", err, 1'b0);
    chk("miss_K1", k1 >> 720, 48'h1B02EFFC7072);
    chk("miss_latency", last_rsp_cyc - last_grant_cyc, 2 + gen_lat);

    // Repeat hit on the other channel, response held for a few cycles.
    p0 = kg_pulses;
    request(1, KEY_A, 1'b1);
    wait_rsp(1, 3, k2, rv, err);
    chk("hit_kg_pulses", kg_pulses - p0, 0);
    chk("hit_rsp_valid", rv, 2'b10);
    chk("hit_latency", last_rsp_cyc - last_grant_cyc, 2);
    chk("hit_same_keys", k2, k1);

    // Direction miss.
    p0 = kg_pulses;
    request(0, KEY_A, 1'b0);
    wait_rsp(0, 0, k2, rv, err);
    chk("dir_kg_pulses", kg_pulses - p0, 1);
    chk("dir_K1_low", k2 & {720'd0, {48{1'b1}}}, 48'h1B02EFFC7072);

    // Timeout, then the same request must go to the generator again.
    gen_dead = 1'b1;
    p0 = kg_pulses;
    request(1, KEY_B, 1'b1);
    wait_rsp(1, 0, k2, rv, err);
    chk("to_rsp_err", err, 1'b1);
    chk("to_latency", last_rsp_cyc - last_grant_cyc, 2 + TIMEOUT);
    gen_dead = 1'b0;
    request(1, KEY_B, 1'b1);
    wait_rsp(1, 0, k2, rv, err);
    chk("to_retry_kg_pulses", kg_pulses - p0, 2);
    chk("to_retry_err", err, 1'b0);

    // Flush coinciding with generator done.
    flush_on_done = 1'b1;
    p0 = kg_pulses;
    request(0, KEY_C, 1'b1);
    wait_rsp(0, 0, k2, rv, err);
    flush_on_done = 1'b0;
    chk("flush_delivered_err", err, 1'b0);
    chk("flush_delivered_K1", k2 >> 720, des_ks(KEY_C, 1'b1) >> 720);
    request(0, KEY_C, 1'b1);
    wait_rsp(0, 0, k2, rv, err);
    chk("flush_next_misses", kg_pulses - p0, 2);
    request(1, KEY_C, 1'b1);
    wait_rsp(1, 0, k2, rv, err);
    chk("refill_then_hit", kg_pulses - p0, 2);

    // Reset while waiting on the generator.
    request(0, KEY_A, 1'b1);
    wait_rsp(0, 0, k2, rv, err);
    gen_dead = 1'b1;
    request(1, KEY_D, 1'b1);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_wait_rsp_valid", rsp_valid, 2'b00);
    chk("rst_wait_kg_key", kg_key, 64'd0);
    chk("rst_wait_rsp_keys", rsp_keys, '0);
    chk("rst_wait_kg_valid_i", kg_valid_i, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    gen_dead = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_idle_rsp_valid", rsp_valid, 2'b00);
    p0 = kg_pulses;
    request(0, KEY_A, 1'b1);
    wait_rsp(0, 0, k2, rv, err);
    chk("post_rst_misses", kg_pulses - p0, 1);
    chk("post_rst_K1", k2 >> 720, 48'h1B02EFFC7072);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
